flip_variable_selector: RTL and testbench

//  Consumes the clause produced by the unsat clause selector (selected_o, valid with its request_q4).

---
 rtl/flip_variable_selector.sv | 183 ++++++++++++++++++
 tb/tb_flip_variable_selector.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/flip_variable_selector.sv
// WalkSAT-SKC flip selection: fetches one break count per clause literal and
// picks a freebie, a noisy random-walk slot, or the greedy minimum-break slot.
module flip_variable_selector #(
    parameter int NSAT                  = 3,
    parameter int LITERAL_ADDRESS_WIDTH = 12,
    parameter int BREAK_WIDTH           = 8,
    parameter int RANDOM_NUM_WIDTH      = 18,
    parameter int NOISE_WIDTH           = 8
) (
    input  logic                                  clk_i,
    input  logic                                  rst_ni,
    input  logic                                  start_i,
    input  logic [NSAT*LITERAL_ADDRESS_WIDTH-1:0] clause_i,
    input  logic [RANDOM_NUM_WIDTH-1:0]           random_i,
    input  logic [NOISE_WIDTH-1:0]                noise_threshold_i,
    output logic                                  bc_rd_en_o,
    output logic [LITERAL_ADDRESS_WIDTH-2:0]      bc_addr_o,
    input  logic [BREAK_WIDTH-1:0]                bc_data_i,
    output logic                                  busy_o,
    output logic                                  done_o,
    output logic                                  flip_valid_o,
    output logic [LITERAL_ADDRESS_WIDTH-2:0]      flip_var_o,
    output logic [BREAK_WIDTH-1:0]                flip_break_o,
    output logic [1:0]                            flip_mode_o,
    output logic                                  err_empty_clause_o
);
    localparam int LAW    = LITERAL_ADDRESS_WIDTH;
    localparam int VW     = LAW - 1;
    localparam int SLOT_W = (NSAT > 1) ? $clog2(NSAT) : 1;
    localparam int CNT_W  = $clog2(NSAT + 1);

    typedef enum logic [1:0] {IDLE, FETCH, DRAIN, DECIDE} state_t;

    typedef struct packed {
        logic                   valid;
        logic [VW-1:0]          var_idx;
        logic [BREAK_WIDTH-1:0] brk;
        logic [1:0]             mode;
    } result_t;

    state_t state_q, state_d;

    logic [NSAT-1:0][VW-1:0]          var_d, var_q;
    logic [NSAT-1:0][BREAK_WIDTH-1:0] brk_q;
    logic [NSAT-1:0]                  slot_vld;
    logic [NOISE_WIDTH-1:0]           noise_q, thr_q;
    logic [SLOT_W-1:0]                pick_q, cnt_q, rd_slot_q;
    logic                             rd_q;
    logic                             zero_found_q, min_found_q;
    logic [SLOT_W-1:0]                zero_slot_q, min_slot_q, walk_slot;
    logic [BREAK_WIDTH-1:0]           min_brk_q;
    logic [CNT_W-1:0]                 nvalid;
    int unsigned                      seen, r_idx;
    result_t                          res;
    logic [NSAT-1:0]                  pol_unused;

    // Only the variable index is needed; polarity does not affect selection.
    for (genvar k = 0; k < NSAT; k++) begin : g_slot
        assign var_d[k]      = clause_i[k*LAW +: VW];
        assign pol_unused[k] = clause_i[k*LAW + VW];
        assign slot_vld[k]   = |var_q[k];
    end

    if (RANDOM_NUM_WIDTH > NOISE_WIDTH + SLOT_W) begin : g_rnd_unused
        logic rnd_unused;
        assign rnd_unused = ^random_i[RANDOM_NUM_WIDTH-1:NOISE_WIDTH+SLOT_W];
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) state_q <= IDLE;
        else         state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start_i) state_d = FETCH;
            FETCH:   if (cnt_q == SLOT_W'(NSAT-1)) state_d = DRAIN;
            DRAIN:   state_d = DECIDE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        bc_rd_en_o = (state_q == FETCH);
        bc_addr_o  = (state_q == FETCH) ? var_q[cnt_q] : '0;
        busy_o     = (state_q != IDLE);
    end

    // Capture runs one cycle behind the address: rd_q/rd_slot_q tag the datum on bc_data_i.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            var_q        <= '0;
            brk_q        <= '0;
            noise_q      <= '0;
            thr_q        <= '0;
            pick_q       <= '0;
            cnt_q        <= '0;
            rd_q         <= 1'b0;
            rd_slot_q    <= '0;
            zero_found_q <= 1'b0;
            zero_slot_q  <= '0;
            min_found_q  <= 1'b0;
            min_slot_q   <= '0;
            min_brk_q    <= '0;
        end else begin
            rd_q      <= (state_q == FETCH);
            rd_slot_q <= cnt_q;
            if (state_q == IDLE && start_i) begin
                var_q        <= var_d;
                noise_q      <= random_i[NOISE_WIDTH-1:0];
                pick_q       <= random_i[NOISE_WIDTH +: SLOT_W];
                thr_q        <= noise_threshold_i;
                cnt_q        <= '0;
                zero_found_q <= 1'b0;
                min_found_q  <= 1'b0;
            end else if (state_q == FETCH) begin
                cnt_q <= cnt_q + 1'b1;
            end
            if (rd_q && slot_vld[rd_slot_q]) begin
                brk_q[rd_slot_q] <= bc_data_i;
                if (bc_data_i == '0 && !zero_found_q) begin
                    zero_found_q <= 1'b1;
                    zero_slot_q  <= rd_slot_q;
                end
                // Strict compare keeps the lowest slot on ties.
                if (!min_found_q || bc_data_i < min_brk_q) begin
                    min_found_q <= 1'b1;
                    min_slot_q  <= rd_slot_q;
                    min_brk_q   <= bc_data_i;
                end
            end
        end
    end

    always_comb begin
        nvalid = '0;
        for (int k = 0; k < NSAT; k++) nvalid = nvalid + CNT_W'(slot_vld[k]);
    end

    always_comb begin
        res       = '0;
        walk_slot = '0;
        seen      = 0;
        r_idx     = 0;
        if (nvalid != '0) r_idx = 32'(pick_q) % 32'(nvalid);
        for (int k = 0; k < NSAT; k++) begin
            if (slot_vld[k]) begin
                if (seen == r_idx) walk_slot = SLOT_W'(k);
                seen = seen + 1;
            end
        end
        if (nvalid == '0) begin
            res = '0;
        end else if (zero_found_q) begin
            res = '{valid: 1'b1, var_idx: var_q[zero_slot_q], brk: '0, mode: 2'd0};
        end else if (noise_q < thr_q) begin
            res = '{valid: 1'b1, var_idx: var_q[walk_slot], brk: brk_q[walk_slot], mode: 2'd1};
        end else begin
            res = '{valid: 1'b1, var_idx: var_q[min_slot_q], brk: min_brk_q, mode: 2'd2};
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            done_o             <= 1'b0;
            flip_valid_o       <= 1'b0;
            flip_var_o         <= '0;
            flip_break_o       <= '0;
            flip_mode_o        <= '0;
            err_empty_clause_o <= 1'b0;
        end else begin
            done_o <= (state_q == DECIDE);
            if (state_q == DECIDE) begin
                flip_valid_o <= res.valid;
                flip_var_o   <= res.var_idx;
                flip_break_o <= res.brk;
                flip_mode_o  <= res.mode;
                if (nvalid == '0) err_empty_clause_o <= 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_flip_variable_selector.sv
// Bench for flip_variable_selector: directed WalkSAT cases, randomized clauses
// against a queue-based reference model, start spam and mid-fetch reset.
module tb_flip_variable_selector;
    logic        clk_i = 1'b0;
    logic        rst_ni;
    logic        start_i;
    logic [35:0] clause_i;
    logic [17:0] random_i;
    logic [7:0]  noise_threshold_i;
    logic        bc_rd_en_o;
    logic [10:0] bc_addr_o;
    logic [7:0]  bc_data_i;
    logic        busy_o, done_o, flip_valid_o, err_empty_clause_o;
    logic [10:0] flip_var_o;
    logic [7:0]  flip_break_o;
    logic [1:0]  flip_mode_o;

    int n_cmp = 0;
    int n_mis = 0;

    logic [7:0]  bc_mem [0:2047];
    logic [10:0] cv [3];
    logic [7:0]  cb [3];
    logic        exp_valid, exp_err;
    logic [10:0] exp_var;
    logic [7:0]  exp_brk;
    logic [1:0]  exp_mode;

    flip_variable_selector dut (
        .clk_i(clk_i), .rst_ni(rst_ni), .start_i(start_i), .clause_i(clause_i),
        .random_i(random_i), .noise_threshold_i(noise_threshold_i),
        .bc_rd_en_o(bc_rd_en_o), .bc_addr_o(bc_addr_o), .bc_data_i(bc_data_i),
        .busy_o(busy_o), .done_o(done_o), .flip_valid_o(flip_valid_o),
        .flip_var_o(flip_var_o), .flip_break_o(flip_break_o), .flip_mode_o(flip_mode_o),
        .err_empty_clause_o(err_empty_clause_o));

    always #5 clk_i = ~clk_i;

    // Registered-read break RAM.
    always @(posedge clk_i) if (bc_rd_en_o) bc_data_i <= bc_mem[bc_addr_o];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_mis++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference: collect valid slots in a queue, then apply the SKC rules in order.
    function automatic void ref_model(input logic [17:0] rnd, input logic [7:0] thr);
        int vs[$];
        int slot, best;
        for (int k = 0; k < 3; k++) if (cv[k] != 0) vs.push_back(k);
        exp_valid = 0; exp_var = 0; exp_brk = 0; exp_mode = 0;
        if (vs.size() == 0) begin
            exp_err = 1;
            return;
        end
        exp_valid = 1;
        foreach (vs[i]) if (cb[vs[i]] == 0) begin
            exp_var = cv[vs[i]]; exp_brk = 0; exp_mode = 0;
            return;
        end
        if (int'(rnd % 256) < int'(thr)) begin
            slot = vs[((rnd / 256) % 4) % vs.size()];
            exp_var = cv[slot]; exp_brk = cb[slot]; exp_mode = 1;
            return;
        end
        best = vs[0];
        foreach (vs[i]) if (cb[vs[i]] < cb[best]) best = vs[i];
        exp_var = cv[best]; exp_brk = cb[best]; exp_mode = 2;
    endfunction

    task automatic run_clause(input string tag, input logic [17:0] rnd, input logic [7:0] thr);
        int k;
        bit got;
        for (int i = 0; i < 3; i++) bc_mem[cv[i]] = cb[i];
        bc_mem[0] = 8'($urandom);
        for (int i = 0; i < 3; i++) clause_i[i*12 +: 12] = {1'($urandom), cv[i]};
        random_i = rnd;
        noise_threshold_i = thr;
        ref_model(rnd, thr);
        start_i = 1'b1;
        @(posedge clk_i);
        @(negedge clk_i);
        start_i = 1'b0;
        chk({tag, ".busy"}, busy_o, 1);
        got = 0;
        for (k = 0; k < 20 && !got; k++) begin
            if (k < 3) begin
                chk({tag, ".rd_en"}, bc_rd_en_o, 1);
                chk({tag, ".addr"}, bc_addr_o, cv[k]);
            end
            if (done_o) got = 1;
            else @(negedge clk_i);
        end
        chk({tag, ".done_seen"}, got, 1);
        chk({tag, ".latency"}, k - 1, 5);
        chk({tag, ".valid"}, flip_valid_o, exp_valid);
        chk({tag, ".var"}, flip_var_o, exp_var);
        chk({tag, ".break"}, flip_break_o, exp_brk);
        chk({tag, ".mode"}, flip_mode_o, exp_mode);
        chk({tag, ".err"}, err_empty_clause_o, exp_err);
        @(negedge clk_i);
        chk({tag, ".done_pulse"}, done_o, 0);
        chk({tag, ".idle"}, busy_o, 0);
    endtask

    initial begin
        int dpos[$];
        rst_ni = 1'b0; start_i = 1'b0; clause_i = '0; random_i = '0;
        noise_threshold_i = '0; exp_err = 0;
        for (int i = 0; i < 2048; i++) bc_mem[i] = 8'($urandom);
        #12;
        chk("reset.busy", busy_o, 0);
        chk("reset.done", done_o, 0);
        chk("reset.rd_en", bc_rd_en_o, 0);
        chk("reset.flip", {flip_valid_o, flip_var_o, flip_break_o, flip_mode_o}, 0);
        chk("reset.err", err_empty_clause_o, 0);
        @(negedge clk_i); rst_ni = 1'b1; @(negedge clk_i);

        cv = '{11'd5, 11'd9, 11'd12};   cb = '{8'd3, 8'd0, 8'd0};
        run_clause("freebie", 18'h0_0000, 8'hFF);
        cv = '{11'd20, 11'd21, 11'd22}; cb = '{8'd4, 8'd2, 8'd2};
        run_clause("greedy", 18'h0_00FF, 8'h10);
        cv = '{11'd30, 11'd31, 11'd32}; cb = '{8'd4, 8'd2, 8'd7};
        run_clause("walk", 18'h0_0205, 8'h80);
        cv = '{11'd40, 11'd0, 11'd42};  cb = '{8'd6, 8'd0, 8'd3};
        run_clause("padding", 18'h0_0300, 8'h80);
        cv = '{11'd50, 11'd51, 11'd52}; cb = '{8'd200, 8'd255, 8'd255};
        run_clause("thr_zero", 18'h0_0000, 8'h00);
        cv = '{11'd60, 11'd61, 11'd62}; cb = '{8'd9, 8'd8, 8'd7};
        run_clause("allones_rnd", 18'h0_03FF, 8'hFF);
        cv = '{11'd0, 11'd0, 11'd0};    cb = '{8'd0, 8'd0, 8'd0};
        run_clause("empty", 18'h0_0000, 8'h80);

        for (int t = 0; t < 40; t++) begin
            for (int i = 0; i < 3; i++) begin
                cv[i] = ($urandom_range(0, 3) == 0) ? 11'd0 : 11'(i*600 + $urandom_range(1, 599));
                cb[i] = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'($urandom_range(0, 5));
            end
            run_clause("rand", 18'($urandom), 8'($urandom));
        end

        // Start held high for 20 cycles: accepts every NSAT+3 cycles.
        cv = '{11'd70, 11'd71, 11'd72}; cb = '{8'd5, 8'd1, 8'd3};
        for (int i = 0; i < 3; i++) bc_mem[cv[i]] = cb[i];
        for (int i = 0; i < 3; i++) clause_i[i*12 +: 12] = {1'b0, cv[i]};
        random_i = 18'h0_00FF; noise_threshold_i = 8'h00;
        start_i = 1'b1;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk_i);
            if (done_o) dpos.push_back(c);
        end
        start_i = 1'b0;
        chk("spam.count", dpos.size(), 3);
        if (dpos.size() == 3) begin
            chk("spam.gap1", dpos[1] - dpos[0], 6);
            chk("spam.gap2", dpos[2] - dpos[1], 6);
        end
        chk("spam.var", flip_var_o, 71);
        repeat (10) @(negedge clk_i);

        // Reset during FETCH aborts with no done.
        cv = '{11'd80, 11'd81, 11'd82}; cb = '{8'd2, 8'd4, 8'd6};
        for (int i = 0; i < 3; i++) clause_i[i*12 +: 12] = {1'b1, cv[i]};
        start_i = 1'b1;
        @(negedge clk_i); start_i = 1'b0;
        @(negedge clk_i);
        chk("rst.in_fetch", bc_rd_en_o, 1);
        rst_ni = 1'b0;
        #1;
        chk("rst.rd_en", bc_rd_en_o, 0);
        chk("rst.busy", busy_o, 0);
        chk("rst.outs", {done_o, flip_valid_o, flip_var_o, flip_break_o, flip_mode_o, err_empty_clause_o}, 0);
        exp_err = 0;
        @(negedge clk_i); rst_ni = 1'b1;
        begin
            int nd = 0;
            for (int c = 0; c < 8; c++) begin
                @(negedge clk_i);
                if (done_o) nd++;
            end
            chk("rst.no_done", nd, 0);
        end
        run_clause("after_rst", 18'h0_00FF, 8'h00);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end
endmodule
